// File: rtl/ecc_secded_decoder.sv
// SECDED (Hamming + overall parity) decoder with one output register stage
// and valid/ready handshakes on both sides, plus saturating error counters.
module ecc_secded_decoder #(
   parameter int DataWidth = 32,
   parameter int CntWidth  = 16,
   // Smallest p with 2**p >= DataWidth + p + 1
   localparam int ParWidth = $clog2(DataWidth + $clog2(DataWidth + 1) + 1),
   localparam int CwWidth  = DataWidth + ParWidth + 1
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 valid_i,
   output logic                 ready_o,
   input  logic [CwWidth-1:0]   cw_i,
   output logic                 valid_o,
   input  logic                 ready_i,
   output logic [DataWidth-1:0] data_o,
   output logic [ParWidth-1:0]  syndrome_o,
   output logic                 single_err_o,
   output logic                 double_err_o,
   input  logic                 cnt_clear_i,
   output logic [CntWidth-1:0]  single_cnt_o,
   output logic [CntWidth-1:0]  double_cnt_o
);

   localparam int NumPos = DataWidth + ParWidth;
   localparam logic [ParWidth-1:0] LastPos = ParWidth'(NumPos);

   // Hamming position that carries data bit k (skips power-of-two positions).
   function automatic int data_pos(input int k);
      int pos;
      int cnt;
      pos = 0;
      cnt = -1;
      while (cnt < k) begin
         pos = pos + 1;
         if ((pos & (pos - 1)) != 0) cnt = cnt + 1;
      end
      return pos;
   endfunction

   logic [ParWidth-1:0]  syndrome;
   logic                 parity;
   logic                 dec_single;
   logic                 dec_double;
   logic [DataWidth-1:0] dec_data;
   logic                 in_fire;
   logic                 out_fire;

   always_comb begin
      syndrome = '0;
      for (int i = 1; i <= NumPos; i++) begin
         if (cw_i[i]) syndrome = syndrome ^ ParWidth'(i);
      end
   end

   assign parity = ^cw_i;

   // Odd parity means one flip (correctable if the syndrome names a real
   // position); even parity with a nonzero syndrome means two flips.
   always_comb begin
      dec_single = 1'b0;
      dec_double = 1'b0;
      if (parity) begin
         if (syndrome <= LastPos) dec_single = 1'b1;
         else                     dec_double = 1'b1;
      end else if (syndrome != '0) begin
         dec_double = 1'b1;
      end
   end

   for (genvar k = 0; k < DataWidth; k++) begin : g_extract
      localparam int Pos = data_pos(k);
      localparam logic [ParWidth-1:0] PosSyn = ParWidth'(Pos);
      assign dec_data[k] = cw_i[Pos] ^ (dec_single && (syndrome == PosSyn));
   end

   assign ready_o  = !valid_o || ready_i;
   assign in_fire  = valid_i && ready_o;
   assign out_fire = valid_o && ready_i;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         valid_o      <= 1'b0;
         data_o       <= '0;
         syndrome_o   <= '0;
         single_err_o <= 1'b0;
         double_err_o <= 1'b0;
      end else if (in_fire) begin
         valid_o      <= 1'b1;
         data_o       <= dec_data;
         syndrome_o   <= syndrome;
         single_err_o <= dec_single;
         double_err_o <= dec_double;
      end else if (out_fire) begin
         valid_o      <= 1'b0;
      end
   end

   // Counters count delivered beats, so they advance on the output handshake.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         single_cnt_o <= '0;
         double_cnt_o <= '0;
      end else if (cnt_clear_i) begin
         single_cnt_o <= '0;
         double_cnt_o <= '0;
      end else begin
         if (out_fire && single_err_o && (single_cnt_o != '1))
            single_cnt_o <= single_cnt_o + CntWidth'(1);
         if (out_fire && double_err_o && (double_cnt_o != '1))
            double_cnt_o <= double_cnt_o + CntWidth'(1);
      end
   end

endmodule

// File: tb/tb_ecc_secded_decoder.sv
// Testbench for ecc_secded_decoder: directed vector table, handshake corner
// sequences and randomized encoded traffic against an encode-and-flip model.
module tb_ecc_secded_decoder;

   localparam int DataWidth = 32;
   localparam int CntWidth  = 2;
   localparam int ParWidth  = 6;
   localparam int CwWidth   = 39;
   localparam int NumPos    = 38;
   localparam int MaxCnt    = (1 << CntWidth) - 1;

   typedef struct {
      logic [DataWidth-1:0] data;
      logic [ParWidth-1:0]  syn;
      logic                 single;
      logic                 dbl;
   } beat_t;

   typedef struct {
      logic [CwWidth-1:0] cw;
      beat_t              exp;
   } vec_t;

   logic                 clk = 1'b0;
   logic                 rst_i = 1'b0;
   logic                 valid_i = 1'b0;
   logic                 ready_o;
   logic [CwWidth-1:0]   cw_i = '0;
   logic                 valid_o;
   logic                 ready_i = 1'b0;
   logic [DataWidth-1:0] data_o;
   logic [ParWidth-1:0]  syndrome_o;
   logic                 single_err_o;
   logic                 double_err_o;
   logic                 cnt_clear_i = 1'b0;
   logic [CntWidth-1:0]  single_cnt_o;
   logic [CntWidth-1:0]  double_cnt_o;

   int n_checks = 0;
   int n_pass   = 0;
   int exp_single_cnt = 0;
   int exp_double_cnt = 0;
   beat_t q[$];
   vec_t vectors[9];

   ecc_secded_decoder #(.DataWidth(DataWidth), .CntWidth(CntWidth)) dut (
      .clk_i        (clk),
      .rst_i        (rst_i),
      .valid_i      (valid_i),
      .ready_o      (ready_o),
      .cw_i         (cw_i),
      .valid_o      (valid_o),
      .ready_i      (ready_i),
      .data_o       (data_o),
      .syndrome_o   (syndrome_o),
      .single_err_o (single_err_o),
      .double_err_o (double_err_o),
      .cnt_clear_i  (cnt_clear_i),
      .single_cnt_o (single_cnt_o),
      .double_cnt_o (double_cnt_o)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout, expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   // Reference encoder: place data, then choose parity bits to zero the syndrome.
   function automatic logic [CwWidth-1:0] encode(input logic [DataWidth-1:0] d);
      logic [CwWidth-1:0] cw;
      int k;
      int s;
      cw = '0;
      k = 0;
      s = 0;
      for (int pos = 1; pos <= NumPos; pos++) begin
         if ((pos & (pos - 1)) != 0) begin
            cw[pos] = d[k];
            k++;
         end
      end
      for (int pos = 1; pos <= NumPos; pos++) if (cw[pos]) s = s ^ pos;
      for (int j = 0; j < ParWidth; j++) cw[1 << j] = s[j];
      cw[0] = ^cw;
      return cw;
   endfunction

   function automatic logic [DataWidth-1:0] extract(input logic [CwWidth-1:0] cw);
      logic [DataWidth-1:0] d;
      int k;
      d = '0;
      k = 0;
      for (int pos = 1; pos <= NumPos; pos++) begin
         if ((pos & (pos - 1)) != 0) begin
            d[k] = cw[pos];
            k++;
         end
      end
      return d;
   endfunction

   // Random beat: encode random data and flip 0, 1 or 2 distinct bits.
   task automatic gen_beat(output logic [CwWidth-1:0] cw, output beat_t b);
      logic [DataWidth-1:0] d;
      int nflip;
      int p1;
      int p2;
      d = $urandom;
      cw = encode(d);
      nflip = int'($urandom_range(0, 2));
      p1 = int'($urandom_range(0, NumPos));
      p2 = (p1 + 1 + int'($urandom_range(0, NumPos - 1))) % (NumPos + 1);
      b.data = d;
      b.syn = '0;
      b.single = 1'b0;
      b.dbl = 1'b0;
      if (nflip == 1) begin
         cw[p1] = ~cw[p1];
         b.syn = ParWidth'(p1);
         b.single = 1'b1;
      end else if (nflip == 2) begin
         cw[p1] = ~cw[p1];
         cw[p2] = ~cw[p2];
         b.syn = ParWidth'(p1 ^ p2);
         b.dbl = 1'b1;
         b.data = extract(cw);
      end
   endtask

   task automatic update_counts(input logic inc_s, input logic inc_d, input logic clr);
      if (clr) begin
         exp_single_cnt = 0;
         exp_double_cnt = 0;
      end else begin
         if (inc_s && exp_single_cnt < MaxCnt) exp_single_cnt++;
         if (inc_d && exp_double_cnt < MaxCnt) exp_double_cnt++;
      end
   endtask

   task automatic check_counts(input string tag);
      check({tag, " single_cnt"}, 64'(single_cnt_o), 64'(exp_single_cnt));
      check({tag, " double_cnt"}, 64'(double_cnt_o), 64'(exp_double_cnt));
   endtask

   task automatic check_output(input string tag, input beat_t e);
      check({tag, " valid_o"}, 64'(valid_o), 64'(1));
      check({tag, " data_o"}, 64'(data_o), 64'(e.data));
      check({tag, " syndrome_o"}, 64'(syndrome_o), 64'(e.syn));
      check({tag, " single_err_o"}, 64'(single_err_o), 64'(e.single));
      check({tag, " double_err_o"}, 64'(double_err_o), 64'(e.dbl));
   endtask

   // One beat with ready_i high: checks one-cycle latency and counter update.
   task automatic apply_stimulus(input string tag, input logic [CwWidth-1:0] cw, input beat_t e);
      @(negedge clk);
      valid_i = 1'b1;
      cw_i = cw;
      ready_i = 1'b1;
      cnt_clear_i = 1'b0;
      #1;
      check({tag, " ready_o"}, 64'(ready_o), 64'(1));
      check({tag, " valid_o before"}, 64'(valid_o), 64'(0));
      @(negedge clk);
      valid_i = 1'b0;
      check_output(tag, e);
      update_counts(e.single, e.dbl, 1'b0);
      @(negedge clk);
      check({tag, " valid_o after"}, 64'(valid_o), 64'(0));
      check_counts(tag);
   endtask

   initial begin
      logic [CwWidth-1:0] cw;
      beat_t b;
      beat_t b8;
      logic out_hs;
      logic in_hs;

      vectors[0] = '{39'h0,           '{32'h0, 6'd0,  1'b0, 1'b0}};
      vectors[1] = '{39'h8,           '{32'h0, 6'd3,  1'b1, 1'b0}};
      vectors[2] = '{39'h6,           '{32'h0, 6'd3,  1'b0, 1'b1}};
      vectors[3] = '{39'h1_0000_0018, '{32'h1, 6'd39, 1'b0, 1'b1}};
      vectors[4] = '{39'h1,           '{32'h0, 6'd0,  1'b1, 1'b0}};
      vectors[5] = '{39'hF,           '{32'h1, 6'd0,  1'b0, 1'b0}};
      vectors[6] = '{39'h40_0000_0000,'{32'h0, 6'd38, 1'b1, 1'b0}};
      vectors[7] = '{39'h1_0001_0117, '{32'h0, 6'd63, 1'b0, 1'b1}};
      vectors[8] = '{39'h2F,          '{32'h1, 6'd5,  1'b1, 1'b0}};
      b8 = vectors[1].exp;

      // Reset values
      #1 rst_i = 1'b1;
      #1;
      check("reset valid_o", 64'(valid_o), 64'(0));
      check("reset data_o", 64'(data_o), 64'(0));
      check("reset syndrome_o", 64'(syndrome_o), 64'(0));
      check("reset single_err_o", 64'(single_err_o), 64'(0));
      check("reset double_err_o", 64'(double_err_o), 64'(0));
      check("reset ready_o", 64'(ready_o), 64'(1));
      check_counts("reset");
      @(negedge clk);
      @(negedge clk);
      rst_i = 1'b0;

      for (int i = 0; i < 9; i++) begin
         apply_stimulus($sformatf("vec%0d", i), vectors[i].cw, vectors[i].exp);
      end

      // Clear counters before the backpressure sequence
      @(negedge clk);
      cnt_clear_i = 1'b1;
      @(negedge clk);
      cnt_clear_i = 1'b0;
      update_counts(1'b0, 1'b0, 1'b1);
      check_counts("clear");

      // Hold a single-error beat under backpressure for 3 cycles
      @(negedge clk);
      valid_i = 1'b1;
      cw_i = 39'h8;
      ready_i = 1'b0;
      @(negedge clk);
      valid_i = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check("hold ready_o", 64'(ready_o), 64'(0));
         check_output("hold", b8);
         check_counts("hold");
         @(negedge clk);
      end

      // Stream 5 more single-error beats at full throughput
      for (int i = 0; i < 5; i++) begin
         valid_i = 1'b1;
         cw_i = 39'h8;
         ready_i = 1'b1;
         #1;
         check("stream ready_o", 64'(ready_o), 64'(1));
         check("stream valid_o", 64'(valid_o), 64'(1));
         @(negedge clk);
      end
      valid_i = 1'b0;
      @(negedge clk);
      check("stream drained valid_o", 64'(valid_o), 64'(0));
      check("stream single_cnt sat", 64'(single_cnt_o), 64'(MaxCnt));

      // Clear wins over an erroring handshake in the same cycle
      valid_i = 1'b1;
      cw_i = 39'h8;
      ready_i = 1'b1;
      @(negedge clk);
      valid_i = 1'b0;
      cnt_clear_i = 1'b1;
      check("preclear single_cnt", 64'(single_cnt_o), 64'(MaxCnt));
      check("preclear single_err_o", 64'(single_err_o), 64'(1));
      @(negedge clk);
      cnt_clear_i = 1'b0;
      check("clear+hs single_cnt", 64'(single_cnt_o), 64'(0));
      check("clear+hs valid_o", 64'(valid_o), 64'(0));
      update_counts(1'b0, 1'b0, 1'b1);

      // Reset asserted while a beat is held
      apply_stimulus("prereset", 39'h6, vectors[2].exp);
      @(negedge clk);
      valid_i = 1'b1;
      cw_i = 39'h8;
      ready_i = 1'b0;
      @(negedge clk);
      valid_i = 1'b0;
      check("midreset held valid_o", 64'(valid_o), 64'(1));
      #2 rst_i = 1'b1;
      #1;
      check("midreset valid_o", 64'(valid_o), 64'(0));
      check("midreset data_o", 64'(data_o), 64'(0));
      check("midreset syndrome_o", 64'(syndrome_o), 64'(0));
      check("midreset single_err_o", 64'(single_err_o), 64'(0));
      check("midreset double_err_o", 64'(double_err_o), 64'(0));
      update_counts(1'b0, 1'b0, 1'b1);
      check_counts("midreset");
      @(negedge clk);
      rst_i = 1'b0;

      // Randomized traffic with random backpressure and clears
      for (int cyc = 0; cyc < 400; cyc++) begin
         @(negedge clk);
         check("rnd valid_o", 64'(valid_o), 64'(q.size() != 0));
         if (q.size() != 0) begin
            check("rnd data_o", 64'(data_o), 64'(q[0].data));
            check("rnd syndrome_o", 64'(syndrome_o), 64'(q[0].syn));
            check("rnd single_err_o", 64'(single_err_o), 64'(q[0].single));
            check("rnd double_err_o", 64'(double_err_o), 64'(q[0].dbl));
         end
         check_counts("rnd");
         valid_i = ($urandom_range(0, 3) != 0);
         ready_i = ($urandom_range(0, 3) != 0);
         cnt_clear_i = ($urandom_range(0, 19) == 0);
         gen_beat(cw, b);
         cw_i = cw;
         #1;
         check("rnd ready_o", 64'(ready_o), 64'(q.size() == 0 || ready_i));
         out_hs = (q.size() != 0) && ready_i;
         in_hs = valid_i && ((q.size() == 0) || ready_i);
         if (out_hs) begin
            update_counts(q[0].single, q[0].dbl, cnt_clear_i);
            void'(q.pop_front());
         end else begin
            update_counts(1'b0, 1'b0, cnt_clear_i);
         end
         if (in_hs) q.push_back(b);
      end

      @(negedge clk);
      valid_i = 1'b0;
      cnt_clear_i = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
